// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : Decodes a complementary PWM pair into period, high times and
//            dead times. Results are published once per period on the A rise.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture #(
  parameter int COUNT_WIDTH = 16,
  parameter int DT_WIDTH    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pwm_A,
  input  logic                   pwm_B,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] high_A,
  output logic [COUNT_WIDTH-1:0] high_B,
  output logic [DT_WIDTH-1:0]    dt_AB,
  output logic [DT_WIDTH-1:0]    dt_BA,
  output logic                   valid,
  output logic                   overflow,
  output logic                   overlap,
  output logic                   timeout
);

  localparam logic [COUNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [COUNT_WIDTH-1:0] c_cnt_one = COUNT_WIDTH'(1);
  localparam logic [DT_WIDTH-1:0]    c_dt_max  = '1;
  localparam logic [DT_WIDTH-1:0]    c_dt_one  = DT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic                   r_a_d;
  logic                   r_b_d;

  logic [COUNT_WIDTH-1:0] r_per_cnt;
  logic [COUNT_WIDTH-1:0] r_high_a_cnt;
  logic [COUNT_WIDTH-1:0] r_high_b_cnt;
  logic [COUNT_WIDTH-1:0] r_sh_high_a;
  logic [COUNT_WIDTH-1:0] r_sh_high_b;
  logic [DT_WIDTH-1:0]    r_dtab_cnt;
  logic [DT_WIDTH-1:0]    r_dtba_cnt;
  logic                   r_dtab_run;
  logic                   r_dtba_run;
  logic [DT_WIDTH-1:0]    r_sh_dtab;

  logic                   w_a;
  logic                   w_b;
  logic                   w_a_rise;
  logic                   w_a_fall;
  logic                   w_b_rise;
  logic                   w_b_fall;
  logic                   w_per_sat;
  logic                   w_track;
  logic                   w_publish;
  logic                   w_timeout_hit;
  logic                   w_any_sat;
  logic [DT_WIDTH-1:0]    w_dtba_now;

  // Input synchronizers plus the delayed copies used for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_a_d    <= 1'b0;
      r_b_d    <= 1'b0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], pwm_A};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], pwm_B};
      r_a_d    <= r_sync_a[SYNC_STAGES-1];
      r_b_d    <= r_sync_b[SYNC_STAGES-1];
    end
  end

  assign w_a       = r_sync_a[SYNC_STAGES-1];
  assign w_b       = r_sync_b[SYNC_STAGES-1];
  assign w_a_rise  = w_a & ~r_a_d;
  assign w_a_fall  = ~w_a & r_a_d;
  assign w_b_rise  = w_b & ~r_b_d;
  assign w_b_fall  = ~w_b & r_b_d;
  assign w_per_sat = (r_per_cnt == c_cnt_max);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_track       = 1'b0;
    w_publish     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_next = S_ARM;
      end
      S_ARM: begin
        w_track = enable;
        if (w_a_rise) w_state_next = S_RUN;
      end
      S_RUN: begin
        w_track       = enable;
        w_publish     = enable & w_a_rise & ~w_per_sat;
        w_timeout_hit = enable & w_per_sat;
        if (w_per_sat) w_state_next = S_ARM;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (!enable) w_state_next = S_IDLE;
  end

  // Period counter only runs between A rises once the capture is armed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_per_cnt <= '0;
    end else if (!enable || (r_state != S_RUN) || w_a_rise) begin
      r_per_cnt <= '0;
    end else if (!w_per_sat) begin
      r_per_cnt <= r_per_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_high_a_cnt <= '0;
      r_sh_high_a  <= '0;
    end else if (!w_track) begin
      r_high_a_cnt <= '0;
      r_sh_high_a  <= '0;
    end else begin
      if (w_a_rise) begin
        r_high_a_cnt <= c_cnt_one;
      end else if (w_a && (r_high_a_cnt != c_cnt_max)) begin
        r_high_a_cnt <= r_high_a_cnt + c_cnt_one;
      end
      if (w_a_fall) begin
        r_sh_high_a <= r_high_a_cnt;
      end else if (w_a_rise) begin
        r_sh_high_a <= '0;
      end
    end
  end

  // A B pulse ending in the A rise cycle itself belongs to the next period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_high_b_cnt <= '0;
      r_sh_high_b  <= '0;
    end else if (!w_track) begin
      r_high_b_cnt <= '0;
      r_sh_high_b  <= '0;
    end else begin
      if (w_b_rise) begin
        r_high_b_cnt <= c_cnt_one;
      end else if (w_b && (r_high_b_cnt != c_cnt_max)) begin
        r_high_b_cnt <= r_high_b_cnt + c_cnt_one;
      end
      if (w_b_fall) begin
        r_sh_high_b <= r_high_b_cnt;
      end else if (w_a_rise) begin
        r_sh_high_b <= '0;
      end
    end
  end

  // The run flag stops the dead-time counter once its closing edge is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dtab_cnt <= '0;
      r_dtab_run <= 1'b0;
      r_sh_dtab  <= '0;
    end else if (!w_track) begin
      r_dtab_cnt <= '0;
      r_dtab_run <= 1'b0;
      r_sh_dtab  <= '0;
    end else begin
      if (w_a_fall && !w_b_rise) begin
        r_dtab_cnt <= c_dt_one;
        r_dtab_run <= 1'b1;
      end else if (w_b_rise) begin
        r_dtab_run <= 1'b0;
      end else if (r_dtab_run && (r_dtab_cnt != c_dt_max)) begin
        r_dtab_cnt <= r_dtab_cnt + c_dt_one;
      end
      if (w_b_rise) begin
        r_sh_dtab <= (r_dtab_run && !w_a_fall) ? r_dtab_cnt : '0;
      end else if (w_a_rise) begin
        r_sh_dtab <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dtba_cnt <= '0;
      r_dtba_run <= 1'b0;
    end else if (!w_track) begin
      r_dtba_cnt <= '0;
      r_dtba_run <= 1'b0;
    end else begin
      if (w_b_fall && !w_a_rise) begin
        r_dtba_cnt <= c_dt_one;
        r_dtba_run <= 1'b1;
      end else if (w_a_rise) begin
        r_dtba_run <= 1'b0;
      end else if (r_dtba_run && (r_dtba_cnt != c_dt_max)) begin
        r_dtba_cnt <= r_dtba_cnt + c_dt_one;
      end
    end
  end

  // dt_BA closes on the publishing edge, so it goes straight to the output.
  assign w_dtba_now = (r_dtba_run && !w_b_fall) ? r_dtba_cnt : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period <= '0;
      high_A <= '0;
      high_B <= '0;
      dt_AB  <= '0;
      dt_BA  <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= w_publish;
      if (w_publish) begin
        period <= r_per_cnt + c_cnt_one;
        high_A <= r_sh_high_a;
        high_B <= r_sh_high_b;
        dt_AB  <= r_sh_dtab;
        dt_BA  <= w_dtba_now;
      end
    end
  end

  assign w_any_sat = w_per_sat
                   | (r_high_a_cnt == c_cnt_max)
                   | (r_high_b_cnt == c_cnt_max)
                   | (r_dtab_cnt == c_dt_max)
                   | (r_dtba_cnt == c_dt_max);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      overlap  <= 1'b0;
      timeout  <= 1'b0;
    end else if (!enable) begin
      overflow <= 1'b0;
      overlap  <= 1'b0;
      timeout  <= 1'b0;
    end else if (w_track) begin
      if (w_any_sat)     overflow <= 1'b1;
      if (w_a && w_b)    overlap  <= 1'b1;
      if (w_timeout_hit) timeout  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Purpose  : Self-checking bench for pwm_capture driven by generated PWM pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

  localparam int COUNT_WIDTH = 16;
  localparam int DT_WIDTH    = 8;
  localparam int SYNC_STAGES = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic                   pwm_A;
  logic                   pwm_B;
  logic [COUNT_WIDTH-1:0] period;
  logic [COUNT_WIDTH-1:0] high_A;
  logic [COUNT_WIDTH-1:0] high_B;
  logic [DT_WIDTH-1:0]    dt_AB;
  logic [DT_WIDTH-1:0]    dt_BA;
  logic                   valid;
  logic                   overflow;
  logic                   overlap;
  logic                   timeout;

  pwm_capture #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .DT_WIDTH    (DT_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pwm_A    (pwm_A),
    .pwm_B    (pwm_B),
    .period   (period),
    .high_A   (high_A),
    .high_B   (high_B),
    .dt_AB    (dt_AB),
    .dt_BA    (dt_BA),
    .valid    (valid),
    .overflow (overflow),
    .overlap  (overlap),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result word layout: {period, high_A, high_B, dt_AB, dt_BA}.
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int          got_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_samp = 0;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back({period, high_A, high_B, dt_AB, dt_BA});
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [7:0] sat_dt(input int v);
    return (v > 255) ? 8'hFF : 8'(v);
  endfunction

  // One PWM period at the pins: A high for ha cycles from index 0, B high over
  // [bs, bs+hb). The expected result follows directly from those positions.
  task automatic run_period(input int p, input int ha, input int bs, input int hb);
    logic [63:0] e;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      pwm_A = (i < ha);
      pwm_B = (hb > 0) && (i >= bs) && (i < bs + hb);
    end
    if (hb == 0) e = {16'(p), 16'(ha), 16'd0, 8'd0, 8'd0};
    else         e = {16'(p), 16'(ha), 16'(hb), sat_dt(bs - ha), sat_dt(p - bs - hb)};
    exp_q.push_back(e);
  endtask

  // Closing A rise that publishes the last full period.
  task automatic tail();
    @(negedge clk);
    pwm_A = 1'b1;
    pwm_B = 1'b0;
    last_samp = cyc + 1;
    repeat (2) @(negedge clk);
    pwm_A = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    pwm_A  = 1'b0;
    pwm_B  = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b0;
    pwm_A  = 1'b0;
    pwm_B  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({period, high_A, high_B, dt_AB, dt_BA} !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_results: got %h expected 0", {period, high_A, high_B, dt_AB, dt_BA});
    end
    n_cmp++;
    if ({valid, overflow, overlap, timeout} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 0000", {valid, overflow, overlap, timeout});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [63:0] g;
    restart();
    repeat (4) run_period(100, 40, 45, 50);
    tail();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL nominal_count: got %0d valids expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++;
      if (g !== exp_q[i]) begin
        n_bad++;
        $display("FAIL nominal_result[%0d]: got %h expected %h", i, g, exp_q[i]);
      end
    end
    n_cmp++;
    if ({overflow, overlap, timeout} !== 3'b000) begin
      n_bad++;
      $display("FAIL nominal_flags: got %b expected 000", {overflow, overlap, timeout});
    end
  endtask

  // Valid appears SYNC_STAGES+1 edges counting the edge that samples A high.
  task automatic test_latency();
    int last;
    restart();
    repeat (3) run_period(100, 40, 45, 50);
    tail();
    n_cmp++;
    if (got_cyc.size() != 3) begin
      n_bad++;
      $display("FAIL latency_count: got %0d valids expected 3", got_cyc.size());
    end
    last = (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : -1;
    n_cmp++;
    if (last != last_samp + SYNC_STAGES) begin
      n_bad++;
      $display("FAIL latency_edge: got valid at edge %0d expected %0d", last, last_samp + SYNC_STAGES);
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      n_cmp++;
      if (got_cyc[i] - got_cyc[i-1] != 100) begin
        n_bad++;
        $display("FAIL latency_spacing[%0d]: got %0d expected 100", i, got_cyc[i] - got_cyc[i-1]);
      end
    end
  endtask

  task automatic test_zero_dt();
    logic [63:0] g;
    restart();
    repeat (2) run_period(100, 40, 40, 50);
    run_period(100, 40, 0, 0);
    run_period(100, 40, 45, 50);
    tail();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL zero_dt_count: got %0d valids expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++;
      if (g !== exp_q[i]) begin
        n_bad++;
        $display("FAIL zero_dt_result[%0d]: got %h expected %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_overlap();
    restart();
    run_period(100, 40, 37, 50);
    n_cmp++;
    if (overlap !== 1'b1) begin
      n_bad++;
      $display("FAIL overlap_set: got %b expected 1", overlap);
    end
    repeat (2) run_period(100, 40, 45, 50);
    n_cmp++;
    if (overlap !== 1'b1) begin
      n_bad++;
      $display("FAIL overlap_sticky: got %b expected 1", overlap);
    end
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({overflow, overlap, timeout} !== 3'b000) begin
      n_bad++;
      $display("FAIL overlap_clear: got %b expected 000", {overflow, overlap, timeout});
    end
  endtask

  task automatic test_saturation();
    logic [63:0] g;
    restart();
    repeat (2) run_period(330, 10, 310, 10);
    tail();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL sat_count: got %0d valids expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++;
      if (g !== exp_q[i]) begin
        n_bad++;
        $display("FAIL sat_result[%0d]: got %h expected %h", i, g, exp_q[i]);
      end
    end
    n_cmp++;
    if ({overflow, overlap, timeout} !== 3'b100) begin
      n_bad++;
      $display("FAIL sat_flags: got %b expected 100", {overflow, overlap, timeout});
    end
  endtask

  task automatic test_random();
    logic [63:0] g;
    int ha, dab, hb, dba;
    restart();
    for (int k = 0; k < 12; k++) begin
      ha  = int'($urandom_range(1, 50));
      dab = int'($urandom_range(0, 12));
      hb  = int'($urandom_range(0, 40));
      dba = int'($urandom_range(1, 12));
      run_period(ha + dab + hb + dba, ha, ha + dab, hb);
    end
    tail();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL random_count: got %0d valids expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++;
      if (g !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random_result[%0d]: got %h expected %h", i, g, exp_q[i]);
      end
    end
    n_cmp++;
    if ({overflow, overlap, timeout} !== 3'b000) begin
      n_bad++;
      $display("FAIL random_flags: got %b expected 000", {overflow, overlap, timeout});
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] g;
    restart();
    repeat (2) run_period(100, 40, 45, 50);
    tail();
    @(negedge clk);
    pwm_A = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({period, high_A, high_B, dt_AB, dt_BA} !== 64'd0) begin
      n_bad++;
      $display("FAIL areset_results: got %h expected 0", {period, high_A, high_B, dt_AB, dt_BA});
    end
    n_cmp++;
    if ({valid, overflow, overlap, timeout} !== 4'b0000) begin
      n_bad++;
      $display("FAIL areset_flags: got %b expected 0000", {valid, overflow, overlap, timeout});
    end
    pwm_A = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    run_period(100, 40, 45, 50);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++;
      $display("FAIL areset_first_period: got %0d valids expected 0", got_q.size());
    end
    run_period(90, 30, 34, 50);
    tail();
    n_cmp++;
    if (got_q.size() != 2) begin
      n_bad++;
      $display("FAIL areset_count: got %0d valids expected 2", got_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_cmp++;
      if (g !== exp_q[i]) begin
        n_bad++;
        $display("FAIL areset_result[%0d]: got %h expected %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [63:0] g;
    restart();
    run_period(100, 40, 45, 50);
    tail();
    for (int i = 0; i < 70000; i++) @(negedge clk);
    n_cmp++;
    if ({overflow, overlap, timeout} !== 3'b101) begin
      n_bad++;
      $display("FAIL timeout_flags: got %b expected 101", {overflow, overlap, timeout});
    end
    n_cmp++;
    if (got_q.size() != 1) begin
      n_bad++;
      $display("FAIL timeout_no_valid: got %0d valids expected 1", got_q.size());
    end
    run_period(100, 40, 45, 50);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_bad++;
      $display("FAIL timeout_rearm: got %0d valids expected 1", got_q.size());
    end
    tail();
    n_cmp++;
    if (got_q.size() != 2) begin
      n_bad++;
      $display("FAIL timeout_resume_count: got %0d valids expected 2", got_q.size());
    end
    g = (got_q.size() > 1) ? got_q[1] : 'x;
    n_cmp++;
    if (g !== exp_q[1]) begin
      n_bad++;
      $display("FAIL timeout_resume_result: got %h expected %h", g, exp_q[1]);
    end
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    pwm_A  = 1'b0;
    pwm_B  = 1'b0;
    test_reset();
    test_nominal();
    test_latency();
    test_zero_dt();
    test_overlap();
    test_saturation();
    test_random();
    test_async_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measurement end of the PWM compare/dead-time path: samples a complementary PWM pair (A/B) and decodes it back into period, high times and both dead-time intervals, in clk cycles.
- Used for closed-loop self-test of the PWM generator outputs and for monitoring externally driven gate signals.
- Results are published atomically once per period at the A rising edge, with a one-cycle valid strobe and sticky fault flags.

Parameters:
- COUNT_WIDTH, 16, width of the period and high-time counters and outputs.
- DT_WIDTH, 8, width of the dead-time counters and outputs.
- SYNC_STAGES, 2, number of input synchronizer flops per PWM input (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  capture enable; low forces IDLE, clears counters and sticky flags.
- pwm_A  input  1  PWM phase A (asynchronous to clk).
- pwm_B  input  1  PWM phase B, complementary to A (asynchronous to clk).
- period  output  COUNT_WIDTH  cycles between consecutive A rising edges.
- high_A  output  COUNT_WIDTH  cycles A high in the last period.
- high_B  output  COUNT_WIDTH  cycles B high, for the B pulse that ended in the last period.
- dt_AB  output  DT_WIDTH  cycles from A fall to B rise.
- dt_BA  output  DT_WIDTH  cycles from B fall to A rise.
- valid  output  1  one-cycle strobe; all result outputs updated that cycle.
- overflow  output  1  sticky: some counter saturated.
- overlap  output  1  sticky: synced A and B both high in the same cycle.
- timeout  output  1  sticky: no A rise within 2^COUNT_WIDTH-1 cycles.

Behaviour:
- Reset (reset=0): all outputs 0, state IDLE, synchronizers and counters 0.
- Sync and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - Edges are detected against a one-cycle-delayed copy of the synced signal.
  - A "rise cycle" is the first cycle in which the synced signal is high; a "fall cycle" is the first cycle in which it is low.
- States:
  - IDLE -> ARM when enable=1.
  - ARM -> RUN on the first A rise; no valid is issued on this transition.
  - RUN -> ARM on period-counter saturation; timeout is set.
  - Any state -> IDLE when enable=0. This clears counters, shadows and sticky flags; result outputs hold their last values.
- Period counter (RUN):
  - On an A rise cycle: publish period = per_cnt+1, then per_cnt <= 0.
  - Otherwise per_cnt increments, saturating at max.
  - Pulses arriving every N cycles report period = N.
- High-time counters (A and B independently):
  - Rise cycle: cnt <= 1.
  - While synced high: cnt increments, saturating.
  - Fall cycle: shadow <= cnt. An H-cycle pulse reports H.
- Dead-time counters:
  - A fall cycle: dtab_cnt <= 1, incrementing each cycle. On a B rise cycle: dt_AB shadow <= dtab_cnt, or 0 if A fall and B rise occur in the same cycle.
  - dt_BA is measured symmetrically from B fall to A rise.
  - dt_BA is captured in the A rise cycle itself and bypasses its shadow directly into the published output.
- Publish (RUN, A rise cycle):
  - At the next clock edge, period/high_A/high_B/dt_AB/dt_BA are loaded from the shadows (dt_BA via bypass) and valid=1 for exactly one cycle.
  - Shadows are then cleared to 0, so any event not seen in a period reports 0.
- Latency:
  - valid is high in the cycle starting SYNC_STAGES+1 clock edges after the first edge that samples pwm_A high.
- Saturation:
  - Any counter at all-ones holds there and sets overflow.
  - A saturated dead-time counter reports max.
- Overlap:
  - Synced A=1 and B=1 in the same cycle (state ARM or RUN) sets overlap.
  - Measurement continues unaffected.
- Sticky flags clear only on reset or enable=0.
- Reset mid-period: everything returns to the reset state; the first period after re-enable produces no valid.

Test Plan:
- Nominal pair: A high 40 / low 60 (period 100); B rises 5 cycles after A falls, high 50, falls 5 before A rises -> after the 2nd A rise, every valid reports period=100, high_A=40, high_B=50, dt_AB=5, dt_BA=5; overlap=0.
- Latency / first period: enable, then first A rise -> no valid; second A rise at pin -> valid exactly SYNC_STAGES+1 edges after sampling; exactly one valid per period.
- Zero dead time: B rises in the same cycle A falls -> dt_AB=0; B stuck low for a full period -> high_B=0, dt_AB=0, dt_BA=0.
- Overlap: B rises 3 cycles before A falls -> overlap=1 and stays set across periods until enable=0.
- Saturation: DT_WIDTH=8, A fall to B rise = 300 cycles -> dt_AB=255, overflow=1. A held low 70000 cycles -> timeout=1, state ARM, no valid until two further A rises.
- Async reset asserted mid-high-pulse -> all outputs 0 immediately; after release and enable, the first valid appears only at the second A rise.
